// File: rtl/uart_tx_engine.sv
// uart_tx_engine: FIFO-buffered UART transmitter with programmable baud, char length, parity, stop bits and break
// Ports: PCLK/PRESETn clock and async active-low reset; wr_en/wr_data push side;
// baud_div/char_len/parity_mode/stop_bits frame config (latched at character start);
// tx_enable gates new characters; break_req holds the line low;
// fifo_level/fifo_full/fifo_empty occupancy; busy/tx_done/tx_error status; Tx serial line.
module uart_tx_engine #(
  parameter int MAX_CHAR   = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic                          wr_en,
  input  logic [MAX_CHAR-1:0]           wr_data,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic [3:0]                    char_len,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop_bits,
  input  logic                          tx_enable,
  input  logic                          break_req,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic                          busy,
  output logic                          tx_done,
  output logic                          tx_error,
  output logic                          Tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK, BRK_END} state_t;
  state_t state, state_n;
  logic [MAX_CHAR-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [MAX_CHAR-1:0] head, mask, shift_q;
  logic [3:0] len_eff, len_q, bit_cnt;
  logic [DIV_WIDTH-1:0] cnt, div_q;
  logic par_en_q, par_bit_q, stop2_q;
  logic tick, last_stop, can_pop, pop, push, start_brk;
  assign head       = mem[rptr];
  assign fifo_full  = fifo_level == LW'(FIFO_DEPTH);
  assign fifo_empty = fifo_level == '0;
  assign len_eff    = (char_len < 4'd5 || char_len > 4'(MAX_CHAR)) ? 4'(MAX_CHAR) : char_len;
  assign tick       = cnt == div_q;
  assign last_stop  = tick && (state == STOP2 || (state == STOP1 && !stop2_q));
  assign can_pop    = tx_enable && !fifo_empty && !break_req;
  // A pop happens either from IDLE or at the last stop boundary, giving gapless back-to-back frames
  assign pop        = (state == IDLE || last_stop) && can_pop;
  // A pop in the same cycle frees a slot, so a write to a full FIFO is still accepted
  assign push       = wr_en && (!fifo_full || pop);
  assign start_brk  = state_n == BREAK && state != BREAK;
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_CHAR; i++) mask[i] = 4'(i) < len_eff;
  end
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = break_req ? BREAK : pop ? START : IDLE;
      START:   state_n = tick ? DATA : START;
      DATA:    state_n = (tick && bit_cnt == len_q - 4'd1) ? (par_en_q ? PARITY : STOP1) : DATA;
      PARITY:  state_n = tick ? STOP1 : PARITY;
      STOP1:   state_n = !tick ? STOP1 : stop2_q ? STOP2 : break_req ? BREAK : pop ? START : IDLE;
      STOP2:   state_n = !tick ? STOP2 : break_req ? BREAK : pop ? START : IDLE;
      BREAK:   state_n = (tick && !break_req) ? BRK_END : BREAK;
      BRK_END: state_n = tick ? IDLE : BRK_END;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    busy    = state != IDLE;
    tx_done = last_stop;
    Tx      = (state == START || state == BREAK) ? 1'b0 :
              state == DATA   ? shift_q[0] :
              state == PARITY ? par_bit_q  : 1'b1;
  end
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      cnt        <= '0;
      div_q      <= '0;
      shift_q    <= '0;
      len_q      <= 4'(MAX_CHAR);
      bit_cnt    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
      tx_error   <= 1'b0;
    end else begin
      cnt        <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
      div_q      <= (pop || start_brk) ? baud_div : div_q;
      bit_cnt    <= state != DATA ? '0 : tick ? bit_cnt + 4'd1 : bit_cnt;
      shift_q    <= pop ? head & mask : (state == DATA && tick) ? shift_q >> 1 : shift_q;
      len_q      <= pop ? len_eff : len_q;
      par_en_q   <= pop ? parity_mode[1] : par_en_q;
      // parity_mode[0] selects odd, which is the inverse of the even (XOR) bit
      par_bit_q  <= pop ? parity_mode[0] ^ (^(head & mask)) : par_bit_q;
      stop2_q    <= pop ? stop_bits : stop2_q;
      wptr       <= push ? wptr + 1'b1 : wptr;
      rptr       <= pop ? rptr + 1'b1 : rptr;
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
      tx_error   <= wr_en && !push;
    end
  always_ff @(posedge PCLK)
    if (push) mem[wptr] <= wr_data;
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: scoreboard bench for uart_tx_engine, frames checked against recorded Tx history at tx_done
module tb_uart_tx_engine;
  logic PCLK = 1'b0, PRESETn = 1'b0, wr_en = 1'b0, stop_bits = 1'b0, tx_enable = 1'b0, break_req = 1'b0;
  logic [7:0] wr_data = '0;
  logic [15:0] baud_div = '0;
  logic [3:0] char_len = 4'd8;
  logic [1:0] parity_mode = '0;
  logic [2:0] fifo_level;
  logic fifo_full, fifo_empty, busy, tx_done, tx_error, Tx;
  int n_chk = 0, n_fail = 0;
  longint cyc = 0, last_done = 0;
  typedef struct { logic [15:0] bits; int nbits; int per; bit b2b; } frame_t;
  frame_t sb[$];
  logic [511:0] hist = '0;
  uart_tx_engine #(.MAX_CHAR(8), .FIFO_DEPTH(4), .DIV_WIDTH(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .wr_en(wr_en), .wr_data(wr_data), .baud_div(baud_div),
    .char_len(char_len), .parity_mode(parity_mode), .stop_bits(stop_bits), .tx_enable(tx_enable),
    .break_req(break_req), .fifo_level(fifo_level), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .busy(busy), .tx_done(tx_done), .tx_error(tx_error), .Tx(Tx));
  always #5 PCLK = ~PCLK;
  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic frame_t make_frame(input logic [7:0] d, input bit b2b);
    frame_t f;
    int len, ones;
    len = (char_len < 5 || char_len > 8) ? 8 : int'(char_len);
    ones = 0;
    f.bits = '0;
    f.nbits = 1;
    for (int i = 0; i < len; i++) begin
      f.bits[f.nbits] = d[i];
      ones += int'(d[i]);
      f.nbits++;
    end
    if (parity_mode[1]) begin
      f.bits[f.nbits] = parity_mode[0] ? (ones % 2 == 0) : (ones % 2 == 1);
      f.nbits++;
    end
    f.bits[f.nbits] = 1'b1;
    f.nbits++;
    if (stop_bits) begin
      f.bits[f.nbits] = 1'b1;
      f.nbits++;
    end
    f.per = int'(baud_div) + 1;
    f.b2b = b2b;
    return f;
  endfunction
  always @(negedge PCLK) begin
    frame_t f;
    logic [511:0] e, m;
    int n;
    cyc++;
    hist = {hist[510:0], Tx};
    if (tx_done) begin
      check("frame_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        f = sb.pop_front();
        n = f.nbits * f.per;
        e = '0;
        m = '0;
        for (int k = 0; k < n; k++) begin
          e[n-1-k] = f.bits[k / f.per];
          m[n-1-k] = 1'b1;
        end
        check("frame", hist & m, e);
        if (f.b2b) check("b2b_gap", cyc - last_done, n);
      end
      last_done = cyc;
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge PCLK);
  endtask
  task automatic push(input logic [7:0] d, input bit sent, input bit b2b);
    wr_en = 1'b1;
    wr_data = d;
    if (sent) sb.push_back(make_frame(d, b2b));
    @(negedge PCLK);
    wr_en = 1'b0;
  endtask
  task automatic wait_idle(input int maxc);
    int i;
    for (i = 0; i < maxc; i++) begin
      if (!busy && fifo_empty && sb.size() == 0) break;
      @(negedge PCLK);
    end
    check("idle_timeout", i < maxc, 1);
  endtask
  task automatic wait_sig(input string name, input bit done_not_busy, input int maxc);
    int i;
    for (i = 0; i < maxc; i++) begin
      if (done_not_busy ? tx_done : busy) break;
      @(negedge PCLK);
    end
    check(name, i < maxc, 1);
  endtask
  initial begin
    logic [15:0] txv, bv;
    int bad;
    tick(2);
    check("rst_Tx", Tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done_err", {tx_done, tx_error}, 0);
    check("rst_level", fifo_level, 0);
    check("rst_empty_full", {fifo_empty, fifo_full}, 2'b10);
    PRESETn = 1'b1;
    tick(1);
    baud_div = 16'd3; char_len = 4'd8; parity_mode = 2'b10; stop_bits = 1'b0; tx_enable = 1'b1;
    sb.push_back('{bits: 16'h054A, nbits: 11, per: 4, b2b: 1'b0});
    push(8'hA5, 1'b0, 1'b0);
    wait_sig("t1_done_timeout", 1'b1, 100);
    check("t1_busy_at_done", busy, 1);
    tick(1);
    check("t1_busy_after_done", busy, 0);
    wait_idle(100);
    baud_div = 16'd0; char_len = 4'd5; parity_mode = 2'b11; stop_bits = 1'b1;
    sb.push_back('{bits: 16'h01BE, nbits: 9, per: 1, b2b: 1'b0});
    push(8'hFF, 1'b0, 1'b0);
    wait_idle(100);
    tx_enable = 1'b0; baud_div = 16'd1; char_len = 4'd8; parity_mode = 2'b00; stop_bits = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(8'h11 * 8'(i + 1), 1'b1, i > 0);
      check("t3_level", fifo_level, i + 1);
    end
    check("t3_full", fifo_full, 1);
    push(8'h55, 1'b0, 1'b0);
    check("t3_overflow_err", tx_error, 1);
    check("t3_overflow_level", fifo_level, 4);
    tick(1);
    check("t3_err_pulse_end", tx_error, 0);
    tx_enable = 1'b1;
    wait_idle(400);
    check("t3_drained_empty", fifo_empty, 1);
    tx_enable = 1'b0;
    push(8'h66, 1'b1, 1'b0);
    push(8'h77, 1'b1, 1'b1);
    push(8'h88, 1'b1, 1'b1);
    push(8'h99, 1'b1, 1'b1);
    check("t4_full", fifo_full, 1);
    tx_enable = 1'b1;
    push(8'hAA, 1'b1, 1'b1);
    check("t4_pushpop_level", fifo_level, 4);
    check("t4_pushpop_err", tx_error, 0);
    wait_idle(400);
    baud_div = 16'd3; char_len = 4'd8; parity_mode = 2'b00; stop_bits = 1'b0;
    push(8'h3C, 1'b1, 1'b0);
    wait_sig("t5_busy_timeout", 1'b0, 20);
    txv = '0;
    bv = '0;
    for (int c = 0; c < 56; c++) begin
      if (c >= 40) begin
        txv[c-40] = Tx;
        bv[c-40] = busy;
      end
      if (c == 6) break_req = 1'b1;
      if (c == 46) break_req = 1'b0;
      @(negedge PCLK);
    end
    check("t5_break_tx", txv, 16'hFF00);
    check("t5_break_busy", bv, 16'h0FFF);
    wait_idle(100);
    push(8'h00, 1'b0, 1'b0);
    push(8'h5A, 1'b0, 1'b0);
    wait_sig("t6_busy_timeout", 1'b0, 20);
    tick(8);
    check("t6_tx_data_low", Tx, 0);
    #2 PRESETn = 1'b0;
    #1;
    check("t6_rst_Tx", Tx, 1);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_level", fifo_level, 0);
    check("t6_rst_empty", fifo_empty, 1);
    sb.delete();
    tick(2);
    PRESETn = 1'b1;
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      if (!Tx || busy) bad++;
      @(negedge PCLK);
    end
    check("t6_no_stale", bad, 0);
    check("sb_empty_end", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
Parametrised UART transmit engine, successor to the fixed-format transmitter. It buffers characters in an internal FIFO and generates its own bit timing from a programmable divisor. It serialises characters with runtime-selectable length, parity and stop bits, and adds break generation and a graceful-stop enable. It sits between the APB register block (push side) and the Tx pad.

Parameters:
MAX_CHAR, 8, widest character in bits; char_len is legal in 5..MAX_CHAR.
FIFO_DEPTH, 16, TX FIFO entries; power of two, at least 2.
DIV_WIDTH, 16, width of the baud divisor.

Ports:
PCLK  input  1  single system clock; all state on rising edge
PRESETn  input  1  asynchronous active-low reset
wr_en  input  1  push wr_data into the FIFO this cycle
wr_data  input  MAX_CHAR  character to push; only bits [char_len-1:0] are sent
baud_div  input  DIV_WIDTH  bit period = baud_div+1 PCLK cycles
char_len  input  4  data bits per character, 5..MAX_CHAR
parity_mode  input  2  0x none; 10 even; 11 odd
stop_bits  input  1  0 = one stop bit; 1 = two stop bits
tx_enable  input  1  permits starting new characters
break_req  input  1  hold line low (break)
fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy
fifo_full  output  1  level == FIFO_DEPTH
fifo_empty  output  1  level == 0
busy  output  1  state != IDLE
tx_done  output  1  one-cycle pulse at the end of each character's last stop bit
tx_error  output  1  one-cycle pulse when wr_en is asserted while full
Tx  output  1  serial line, idle high

Behaviour:
- Reset (async, PRESETn low):
  - Tx=1, busy=0, tx_done=0, tx_error=0.
  - FIFO emptied: fifo_level=0, fifo_empty=1, fifo_full=0.
  - State IDLE, divisor counter 0.
  - Applies immediately, including mid-frame. Tx must not glitch low.
- FIFO:
  - Synchronous write/read pointers with wrap at FIFO_DEPTH.
  - Write while full: data dropped, level unchanged, tx_error pulses the next cycle.
  - Push and pop in the same cycle: level unchanged. When full, the pop frees the slot and the write is accepted with no error.
- Baud timing:
  - A bit counter runs 0..baud_div. A bit boundary occurs when the counter equals baud_div; the counter then reloads 0.
  - baud_div=0 gives 1-cycle bits.
  - baud_div is sampled at character start and held for the character.
- Character start: char_len, parity_mode and stop_bits are latched at the pop; changes mid-character have no effect.
- States (each non-IDLE state lasts exactly one bit period unless noted):
  - IDLE: Tx=1.
    - break_req=1: go to BREAK.
    - else tx_enable=1 and !fifo_empty: pop head, latch config, go to START. The first START cycle follows the pop cycle.
  - START: Tx=0; then DATA.
  - DATA: Tx=shift_reg[0], LSB first; shift right at each boundary. After char_len bits, go to PARITY if parity_mode[1], else STOP1.
  - PARITY:
    - Even: Tx=^data.
    - Odd: Tx=~^data.
    - data is the char_len-bit value only.
    - Then STOP1.
  - STOP1: Tx=1; then STOP2 if stop_bits, else the end-of-character decision.
  - STOP2: Tx=1; then the end-of-character decision.
  - End-of-character decision, taken at the last stop-bit boundary:
    - tx_done pulses that cycle.
    - break_req: go to BREAK.
    - else tx_enable and !fifo_empty: pop and go straight to START, with no idle gap between characters.
    - else IDLE.
  - BREAK: Tx=0 while break_req=1, counted in whole bit periods. After break_req falls, finish the current bit period, drive Tx=1 for one full bit period, then go to IDLE.
- tx_enable deasserted mid-character: the current character completes; no new pop.
- Illegal char_len (<5 or >MAX_CHAR) at pop: clamp to MAX_CHAR.
- busy=1 in every state except IDLE.

Test Plan:
- Even-parity 8-bit frame:
  - Stimulus: baud_div=3, char_len=8, parity=10, stop_bits=0, push 8'hA5, tx_enable=1.
  - Tx sequence: 0 | 1,0,1,0,0,1,0,1 | 0 | 1, each bit 4 cycles, 44 cycles total.
  - tx_done pulses once; busy falls the cycle after.
- Odd-parity 5-bit frame, two stop bits:
  - Stimulus: char_len=5, parity=11, stop_bits=1, push 8'hFF, baud_div=0.
  - Tx sequence: 0,1,1,1,1,1,0,1,1 (9 cycles); bits [7:5] never appear.
- FIFO overflow then drain:
  - Stimulus: FIFO_DEPTH=4, tx_enable=0, push 5 characters.
  - After the 4th push: fifo_full=1, level=4. The 5th push gives one tx_error pulse and level stays 4.
  - Set tx_enable=1: 4 frames sent back-to-back with no Tx high gap beyond the stop bits; fifo_empty=1 at the end.
- Simultaneous push and pop while full: level stays at FIFO_DEPTH, tx_error=0, and the pushed character is transmitted in order.
- Break during a frame:
  - Stimulus: assert break_req mid-DATA for 10 bit periods.
  - The frame completes normally, then Tx=0 until release rounded to a bit boundary, then 1 bit of Tx=1, then IDLE.
- Reset mid-frame: PRESETn low during DATA. Tx=1 asynchronously, level=0, busy=0; after release no stale character is sent.
